// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-N stream demultiplexer: default geometry and counter width.
package demux_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int N_CH_DEF   = 8;
  localparam int CNT_W      = 16;
endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: valid flag plus data register, reloadable while draining.
module demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
);

  // Free when empty or emptying this cycle, so a full slot can be refilled without a bubble.
  assign free = ~valid | ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1_to_n_stream.sv
// 1-to-N valid/ready stream demultiplexer with per-channel one-entry slots.
// Optional broadcast to all channels is built only when DEMUX_BCAST_EN is defined.
module demux_1_to_n_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_CH   = N_CH_DEF,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_bcast,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   sel_err,
  output logic [CNT_W-1:0]       xfer_cnt
);

  localparam int SEL_SPAN = 2 ** SEL_W;

  logic [N_CH-1:0]     free;
  logic [N_CH-1:0]     hit;
  logic [N_CH-1:0]     load;
  logic [SEL_SPAN-1:0] free_pad;
  logic                sel_ok;
  logic                bcast;
  logic                accept;

  // Unused select codes read as free so an out-of-range beat is always taken and dropped.
  always_comb begin
    free_pad            = '1;
    free_pad[N_CH-1:0]  = free;
    hit                 = '0;
    for (int k = 0; k < N_CH; k++) hit[k] = (int'(in_sel) == k);
  end

  assign sel_ok = (int'(in_sel) < N_CH);

`ifdef DEMUX_BCAST_EN
  logic all_free;
  assign bcast    = in_bcast;
  assign all_free = &free;
  assign in_ready = ~rst & (bcast ? all_free : free_pad[in_sel]);
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;
  assign bcast        = 1'b0;
  assign in_ready     = ~rst & free_pad[in_sel];
`endif

  assign accept = in_valid & in_ready;
  assign load   = {N_CH{accept}} & ({N_CH{bcast}} | ({N_CH{sel_ok}} & hit));

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*DATA_W +: DATA_W]),
      .free      (free[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      sel_err <= accept & ~bcast & ~sel_ok;
      if (accept & (bcast | sel_ok)) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: doc/demux_1_to_n_stream.md
DEMUX_1_TO_N_STREAM -- requirements
Module: demux_1_to_n_stream

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_W, 8, payload width in bits (>=1).
- N_CH, 8, number of output channels (2..64).
- SEL_W, $clog2(N_CH), select width; derived, not overridden.
REQ-002 Ports SHALL be as follows:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat offered.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_bcast  in  1  broadcast request; used only with DEMUX_BCAST_EN.
- out_valid  out  N_CH  per-channel beat held.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DATA_W  channel k payload at bits [k*DATA_W +: DATA_W].
- sel_err  out  1  one-cycle pulse: a beat with out-of-range in_sel was dropped.
- xfer_cnt  out  16  count of accepted, non-dropped input beats.

Function
REQ-003 Each channel SHALL own a one-entry output slot (valid flag plus data register); a transfer occurs on a side when valid and ready are both high at a clock edge.
REQ-004 A beat accepted at edge t SHALL appear on out_valid[in_sel]/out_data slot in_sel after edge t (latency 1 cycle); no other channel SHALL change.
REQ-005 For in_sel < N_CH, in_ready SHALL equal (~out_valid[in_sel] | out_ready[in_sel]), combinationally; a full slot draining in the same cycle SHALL be reloaded with no bubble.
REQ-006 While out_valid[k]=1 and out_ready[k]=0, out_data slot k SHALL hold stable.
REQ-007 A slot drained with no new beat loaded SHALL clear out_valid[k] the following cycle; data register value is then don't-care but SHALL retain its last value.
REQ-008 For in_sel >= N_CH (only possible when N_CH is not a power of two), in_ready SHALL be 1, the beat SHALL be discarded, and sel_err SHALL pulse high for exactly the cycle after acceptance.
REQ-009 in_ready SHALL be 0 while rst is high.
REQ-010 xfer_cnt SHALL increment by 1 per accepted non-dropped beat (a broadcast counts once) and wrap from 16'hFFFF to 0.
REQ-011 in_data, in_sel and in_bcast SHALL be ignored when in_valid=0; out_ready of idle channels SHALL have no effect.

Reset
REQ-012 Asserting rst SHALL immediately clear all out_valid, out_data, sel_err and xfer_cnt to 0, discarding any held beats, including mid-transfer.
REQ-013 The first beat SHALL be accepted no earlier than the first rising edge of clk after rst deasserts.

Configuration
REQ-014 With macro DEMUX_BCAST_EN defined, an input beat with in_bcast=1 SHALL be accepted only when every slot is empty or draining this cycle, and SHALL load all N_CH slots simultaneously; in_sel SHALL be ignored and sel_err SHALL not pulse.
REQ-015 Without DEMUX_BCAST_EN, in_bcast SHALL remain a port but SHALL be ignored (treated as 0), and no broadcast logic SHALL be synthesised.

Structure
REQ-016 Package demux_pkg SHALL hold default DATA_W/N_CH constants and the xfer_cnt width constant (16).
REQ-017 The per-channel slot SHALL be a sub-module demux_slot (valid/ready one-entry register, DATA_W parameter), instantiated N_CH times by a generate loop.

Verification
REQ-018 Reset then in_valid=1, in_sel=3, in_data=8'hA5, out_ready all 1 -> next cycle out_valid=8'b0000_1000, slot 3 = 8'hA5, xfer_cnt=1.
REQ-019 out_ready[2]=0, two beats to channel 2 (8'h11, 8'h22) -> first held stable, in_ready=0 for second until out_ready[2]=1, then 8'h22 follows with no bubble.
REQ-020 N_CH=6, in_sel=7 -> in_ready=1, no out_valid change, sel_err high one cycle, xfer_cnt unchanged.
REQ-021 Slots 0/5 full, assert rst asynchronously mid-cycle -> out_valid=0, xfer_cnt=0 before next edge.
REQ-022 DEMUX_BCAST_EN, slot 4 stalled, in_bcast=1 with 8'h3C -> in_ready=0 until out_ready[4]=1, then all slots = 8'h3C, xfer_cnt+1.
REQ-023 65536 single-channel beats -> xfer_cnt wraps to 0.
